mem_access_stage: RTL and testbench



---
 rtl/mem_access_stage.sv | 178 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: aligned data-memory access over a req/gnt/rvalid bus,
// load extraction/extension, store strobes, bus timeout, and the MEM/WB register.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_rs2_val_for_store,
  input  logic [4:0]  mem_rd_addr,
  input  logic        mem_reg_write,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic [1:0]  mem_load_size,
  input  logic [1:0]  mem_store_size,
  input  logic        mem_load_signed,
  input  logic [31:0] mem_wb_candidate,
  input  logic        mem_csr_hit,
  input  logic [31:0] mem_csr_data,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_wstrb,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        mem_stall,
  output logic [31:0] wb_pc,
  output logic [4:0]  wb_rd_addr,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic        wb_misalign,
  output logic        wb_bus_err
);

  typedef enum logic [1:0] {IDLE, GNT, RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;

  logic        is_access, is_store, is_load, misalign, aligned, timeout;
  logic        complete, load_done, bus_err;
  logic [1:0]  size, addr_lo;
  logic [31:0] shifted, load_val, nonload_val;
  logic [3:0]  strb;

  assign is_access = mem_mem_read | mem_mem_write;
  assign is_store  = mem_mem_write;
  assign is_load   = mem_mem_read & ~mem_mem_write;
  assign size      = is_store ? mem_store_size : mem_load_size;
  assign addr_lo   = mem_alu_result[1:0];
  assign misalign  = is_access & (((size == 2'b01) & addr_lo[0]) |
                                  (size[1] & (addr_lo != 2'b00)));
  assign aligned   = is_access & ~misalign;
  // A load granted late enters RESP already past the limit, hence >= rather than ==.
  assign timeout   = (state != IDLE) && (cnt >= TO_LAST);

  always_comb begin
    complete  = 1'b0;
    load_done = 1'b0;
    bus_err   = 1'b0;
    if (!aligned) begin
      complete = 1'b1;
    end else begin
      case (state)
        IDLE: complete = dbus_gnt & is_store;
        GNT: begin
          if (dbus_gnt) begin
            complete = is_store;
          end else if (timeout) begin
            complete = 1'b1;
            bus_err  = 1'b1;
          end
        end
        RESP: begin
          if (dbus_rvalid) begin
            complete  = 1'b1;
            load_done = 1'b1;
          end else if (timeout) begin
            complete = 1'b1;
            bus_err  = 1'b1;
          end
        end
        default: complete = 1'b1;
      endcase
    end
  end

  always_comb begin
    strb       = 4'b1111;
    dbus_wdata = mem_rs2_val_for_store;
    case (mem_store_size)
      2'b00: begin
        strb       = 4'b0001 << addr_lo;
        dbus_wdata = {4{mem_rs2_val_for_store[7:0]}};
      end
      2'b01: begin
        strb       = addr_lo[1] ? 4'b1100 : 4'b0011;
        dbus_wdata = {2{mem_rs2_val_for_store[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = dbus_rdata >> {addr_lo, 3'b000};
    case (mem_load_size)
      2'b00:   load_val = {{24{mem_load_signed & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{mem_load_signed & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  assign nonload_val = mem_csr_hit ? mem_csr_data : mem_wb_candidate;
  assign mem_stall   = aligned & ~complete;
  // Gated by reset so the bus sees no request while the stage is held in reset.
  assign dbus_req    = rst & aligned & (state != RESP);
  assign dbus_we     = is_store;
  assign dbus_addr   = {mem_alu_result[31:2], 2'b00};
  assign dbus_wstrb  = is_store ? strb : 4'b0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (aligned && !dbus_gnt) begin
            state <= GNT;
            cnt   <= 8'd0;
          end else if (aligned && is_load) begin
            state <= RESP;
            cnt   <= 8'd0;
          end
        end
        GNT: begin
          cnt <= cnt + 8'd1;
          if (bus_err)       state <= IDLE;
          else if (dbus_gnt) state <= is_store ? IDLE : RESP;
        end
        RESP: begin
          cnt <= cnt + 8'd1;
          if (complete) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stalled cycles push a bubble; pc/rd/data are simply held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_pc        <= 32'd0;
      wb_rd_addr   <= 5'd0;
      wb_reg_write <= 1'b0;
      wb_data      <= 32'd0;
      wb_misalign  <= 1'b0;
      wb_bus_err   <= 1'b0;
    end else if (complete) begin
      wb_pc        <= mem_pc;
      wb_rd_addr   <= mem_rd_addr;
      wb_reg_write <= mem_reg_write & ~misalign & ~bus_err;
      wb_data      <= load_done ? load_val : nonload_val;
      wb_misalign  <= misalign;
      wb_bus_err   <= bus_err;
    end else begin
      wb_reg_write <= 1'b0;
      wb_misalign  <= 1'b0;
      wb_bus_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stores, loads, misalignment, timeout and reset.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_pc, mem_alu_result, mem_rs2_val_for_store, mem_wb_candidate, mem_csr_data;
  logic [4:0]  mem_rd_addr;
  logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_load_signed, mem_csr_hit;
  logic [1:0]  mem_load_size, mem_store_size;
  logic        dbus_gnt, dbus_rvalid, gnt_to, rvalid_to;
  logic [31:0] dbus_rdata;

  logic        dbus_req, dbus_we, mem_stall, wb_reg_write, wb_misalign, wb_bus_err;
  logic [31:0] dbus_addr, dbus_wdata, wb_pc, wb_data;
  logic [3:0]  dbus_wstrb;
  logic [4:0]  wb_rd_addr;

  logic        req_to, we_to, stall_to, reg_write_to, misalign_to, bus_err_to;
  logic [31:0] addr_to, wdata_to, pc_to, data_to;
  logic [3:0]  wstrb_to;
  logic [4:0]  rd_to;

  int compared = 0;
  int mismatched = 0;
  int stalls;
  logic done;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .mem_pc(mem_pc), .mem_alu_result(mem_alu_result),
    .mem_rs2_val_for_store(mem_rs2_val_for_store), .mem_rd_addr(mem_rd_addr),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_load_size(mem_load_size), .mem_store_size(mem_store_size),
    .mem_load_signed(mem_load_signed), .mem_wb_candidate(mem_wb_candidate),
    .mem_csr_hit(mem_csr_hit), .mem_csr_data(mem_csr_data),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_wstrb(dbus_wstrb), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
    .dbus_rdata(dbus_rdata), .mem_stall(mem_stall), .wb_pc(wb_pc), .wb_rd_addr(wb_rd_addr),
    .wb_reg_write(wb_reg_write), .wb_data(wb_data), .wb_misalign(wb_misalign),
    .wb_bus_err(wb_bus_err)
  );

  // Second instance with a short timeout; shares the pipeline inputs, owns its bus handshake.
  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .mem_pc(mem_pc), .mem_alu_result(mem_alu_result),
    .mem_rs2_val_for_store(mem_rs2_val_for_store), .mem_rd_addr(mem_rd_addr),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_load_size(mem_load_size), .mem_store_size(mem_store_size),
    .mem_load_signed(mem_load_signed), .mem_wb_candidate(mem_wb_candidate),
    .mem_csr_hit(mem_csr_hit), .mem_csr_data(mem_csr_data),
    .dbus_req(req_to), .dbus_we(we_to), .dbus_addr(addr_to), .dbus_wdata(wdata_to),
    .dbus_wstrb(wstrb_to), .dbus_gnt(gnt_to), .dbus_rvalid(rvalid_to),
    .dbus_rdata(dbus_rdata), .mem_stall(stall_to), .wb_pc(pc_to), .wb_rd_addr(rd_to),
    .wb_reg_write(reg_write_to), .wb_data(data_to), .wb_misalign(misalign_to),
    .wb_bus_err(bus_err_to)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] rs2,
                               input logic rd_op, input logic wr_op, input logic [1:0] size,
                               input logic sgn, input logic [4:0] rd, input logic rw,
                               input logic [31:0] cand);
    mem_pc = pc;            mem_alu_result = addr;   mem_rs2_val_for_store = rs2;
    mem_mem_read = rd_op;   mem_mem_write = wr_op;   mem_load_size = size;
    mem_store_size = size;  mem_load_signed = sgn;   mem_rd_addr = rd;
    mem_reg_write = rw;     mem_wb_candidate = cand; mem_csr_hit = 1'b0;
    mem_csr_data = 32'h0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = 0; gnt_to = 0; rvalid_to = 0;
    applyStimulus(32'h0, 32'h0, 32'h0, 0, 0, 2'b00, 0, 5'd0, 0, 32'h0);
    #1;
    checkOutput("rst_req", dbus_req, 0);
    checkOutput("rst_wb_pc", wb_pc, 0);
    checkOutput("rst_wb_data", wb_data, 0);
    checkOutput("rst_wb_rw", wb_reg_write, 0);
    @(negedge clk);
    rst = 1'b1;

    // Store byte, granted immediately
    @(negedge clk);
    applyStimulus(32'h100, 32'h1003, 32'h000000A5, 0, 1, 2'b00, 0, 5'd0, 0, 32'h0);
    dbus_gnt = 1;
    #1;
    checkOutput("sb_strb", dbus_wstrb, 4'b1000);
    checkOutput("sb_wdata", dbus_wdata, 32'hA5A5A5A5);
    checkOutput("sb_addr", dbus_addr, 32'h1000);
    checkOutput("sb_req", dbus_req, 1);
    checkOutput("sb_we", dbus_we, 1);
    checkOutput("sb_stall", mem_stall, 0);
    @(posedge clk); #1;
    checkOutput("sb_wb_pc", wb_pc, 32'h100);

    // Store half in the upper half-word
    @(negedge clk);
    applyStimulus(32'h104, 32'h1002, 32'h1234BEEF, 0, 1, 2'b01, 0, 5'd0, 0, 32'h0);
    #1;
    checkOutput("sh_strb", dbus_wstrb, 4'b1100);
    checkOutput("sh_wdata", dbus_wdata, 32'hBEEFBEEF);

    // Signed load byte: gnt in cycle 0, rvalid in cycle 1
    @(negedge clk);
    applyStimulus(32'h200, 32'h2001, 32'h0, 1, 0, 2'b00, 1, 5'd5, 1, 32'h0);
    dbus_gnt = 1;
    #1;
    checkOutput("lb_stall0", mem_stall, 1);
    checkOutput("lb_req0", dbus_req, 1);
    checkOutput("lb_strb", dbus_wstrb, 4'b0000);
    @(posedge clk); #1;
    checkOutput("lb_bubble", wb_reg_write, 0);
    @(negedge clk);
    dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = 32'h00008000;
    #1;
    checkOutput("lb_stall1", mem_stall, 0);
    checkOutput("lb_req1", dbus_req, 0);
    @(posedge clk); #1;
    checkOutput("lb_data", wb_data, 32'hFFFFFF80);
    checkOutput("lb_rw", wb_reg_write, 1);
    checkOutput("lb_rd", wb_rd_addr, 5);

    // Non-memory write-back, then CSR select
    @(negedge clk);
    dbus_rvalid = 0;
    applyStimulus(32'h204, 32'h0, 32'h0, 0, 0, 2'b10, 0, 5'd7, 1, 32'h13572468);
    @(posedge clk); #1;
    checkOutput("alu_data", wb_data, 32'h13572468);
    @(negedge clk);
    mem_csr_hit = 1; mem_csr_data = 32'h00000B00;
    @(posedge clk); #1;
    checkOutput("csr_data", wb_data, 32'h00000B00);

    // Unsigned load half: gnt after 3 cycles, rvalid 2 cycles later
    @(negedge clk);
    applyStimulus(32'h300, 32'h2002, 32'h0, 1, 0, 2'b01, 0, 5'd9, 1, 32'h0);
    dbus_rdata = 32'hBEEF1234;
    stalls = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      dbus_gnt = (i == 3);
      dbus_rvalid = (i == 5);
      #1;
      if (mem_stall) stalls++; else done = 1;
      @(posedge clk); #1;
      if (!done) begin
        checkOutput("lh_bubble", wb_reg_write, 0);
        @(negedge clk);
      end
    end
    checkOutput("lh_done", done, 1);
    checkOutput("lh_stalls", stalls, 5);
    checkOutput("lh_data", wb_data, 32'h0000BEEF);
    checkOutput("lh_rw", wb_reg_write, 1);

    // Misaligned load word
    @(negedge clk);
    dbus_gnt = 0; dbus_rvalid = 0;
    applyStimulus(32'h400, 32'h3002, 32'h0, 1, 0, 2'b10, 0, 5'd4, 1, 32'h0);
    #1;
    checkOutput("mis_req", dbus_req, 0);
    checkOutput("mis_stall", mem_stall, 0);
    @(posedge clk); #1;
    checkOutput("mis_flag", wb_misalign, 1);
    checkOutput("mis_rw", wb_reg_write, 0);

    // Timeout on the short-limit instance; gnt never arrives
    pulseReset();
    @(negedge clk);
    applyStimulus(32'h500, 32'h4000, 32'h0, 1, 0, 2'b10, 0, 5'd6, 1, 32'h0);
    gnt_to = 0; rvalid_to = 0;
    stalls = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (stall_to) stalls++; else done = 1;
      @(posedge clk); #1;
      if (!done) begin
        checkOutput("to_bubble", reg_write_to, 0);
        @(negedge clk);
      end
    end
    checkOutput("to_done", done, 1);
    checkOutput("to_stalls", stalls, 4);
    checkOutput("to_err", bus_err_to, 1);
    checkOutput("to_rw", reg_write_to, 0);
    @(negedge clk);
    applyStimulus(32'h504, 32'h0, 32'h0, 0, 0, 2'b10, 0, 5'd2, 1, 32'hCAFE0001);
    rvalid_to = 1;
    #1;
    checkOutput("stray_stall", stall_to, 0);
    @(posedge clk); #1;
    checkOutput("stray_err", bus_err_to, 0);
    checkOutput("stray_data", data_to, 32'hCAFE0001);
    @(negedge clk);
    applyStimulus(32'h508, 32'h4000, 32'h0, 1, 0, 2'b10, 0, 5'd6, 1, 32'h0);
    #1;
    checkOutput("stray_idle_req", req_to, 1);
    checkOutput("stray_idle_stall", stall_to, 1);
    rvalid_to = 0;

    // Reset while in RESP, then a fresh store
    pulseReset();
    @(negedge clk);
    applyStimulus(32'h700, 32'h0, 32'h0, 0, 0, 2'b10, 0, 5'd3, 1, 32'h11112222);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(32'h704, 32'h5000, 32'h0, 1, 0, 2'b10, 0, 5'd8, 1, 32'h0);
    dbus_gnt = 1;
    @(posedge clk);
    @(negedge clk);
    dbus_gnt = 0; dbus_rvalid = 0;
    #1;
    checkOutput("resp_req", dbus_req, 0);
    checkOutput("resp_stall", mem_stall, 1);
    rst = 1'b0;
    #1;
    checkOutput("arst_req", dbus_req, 0);
    checkOutput("arst_wb_pc", wb_pc, 0);
    checkOutput("arst_wb_data", wb_data, 0);
    checkOutput("arst_wb_rd", wb_rd_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(32'h708, 32'h6000, 32'h12345678, 0, 1, 2'b10, 0, 5'd0, 0, 32'h0);
    dbus_gnt = 1;
    #1;
    checkOutput("post_strb", dbus_wstrb, 4'b1111);
    checkOutput("post_wdata", dbus_wdata, 32'h12345678);
    checkOutput("post_stall", mem_stall, 0);
    @(posedge clk); #1;
    checkOutput("post_wb_pc", wb_pc, 32'h708);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
